// File: rtl/fpga.sv
// Shared serial-bus transmitter: round-robin arbitration over 16 senders,
// each granted 77-bit frame is latched and shifted out MSB-first on bus_out.
module fpga (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  CRC1,  CRC2,  CRC3,  CRC4,  CRC5,  CRC6,  CRC7,  CRC8,
  input  logic [3:0]  CRC9,  CRC10, CRC11, CRC12, CRC13, CRC14, CRC15, CRC16,
  input  logic [63:0] Data1,  Data2,  Data3,  Data4,  Data5,  Data6,  Data7,  Data8,
  input  logic [63:0] Data9,  Data10, Data11, Data12, Data13, Data14, Data15, Data16,
  input  logic [3:0]  receiverAddr1,  receiverAddr2,  receiverAddr3,  receiverAddr4,
  input  logic [3:0]  receiverAddr5,  receiverAddr6,  receiverAddr7,  receiverAddr8,
  input  logic [3:0]  receiverAddr9,  receiverAddr10, receiverAddr11, receiverAddr12,
  input  logic [3:0]  receiverAddr13, receiverAddr14, receiverAddr15, receiverAddr16,
  input  logic [15:0] mod,
  output logic        bus_out
);
  localparam int FRAME_W = 77;
  localparam logic [6:0] LAST_CNT = 7'd76;

  typedef enum logic {IDLE, SEND} state_t;

  state_t              r_state, w_next;
  logic [FRAME_W-1:0]  r_shift, w_frame;
  logic [6:0]          r_cnt;
  logic [3:0]          r_ptr, w_win, w_idx;
  logic                w_found;

  logic [15:0][63:0]   w_data;
  logic [15:0][3:0]    w_crc, w_raddr;

  // Element 0 holds sender 1.
  assign w_data  = {Data16, Data15, Data14, Data13, Data12, Data11, Data10, Data9,
                    Data8,  Data7,  Data6,  Data5,  Data4,  Data3,  Data2,  Data1};
  assign w_crc   = {CRC16, CRC15, CRC14, CRC13, CRC12, CRC11, CRC10, CRC9,
                    CRC8,  CRC7,  CRC6,  CRC5,  CRC4,  CRC3,  CRC2,  CRC1};
  assign w_raddr = {receiverAddr16, receiverAddr15, receiverAddr14, receiverAddr13,
                    receiverAddr12, receiverAddr11, receiverAddr10, receiverAddr9,
                    receiverAddr8,  receiverAddr7,  receiverAddr6,  receiverAddr5,
                    receiverAddr4,  receiverAddr3,  receiverAddr2,  receiverAddr1};

  // r_ptr is the first sender examined; it sits one past the last grant.
  always_comb begin
    w_win   = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int k = 0; k < 16; k++) begin
      w_idx = r_ptr + 4'(k);
      if (!w_found && mod[w_idx]) begin
        w_win   = w_idx;
        w_found = 1'b1;
      end
    end
  end

  assign w_frame = {1'b1, w_win, w_raddr[w_win], w_data[w_win], w_crc[w_win]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_found) w_next = SEND;
      SEND:    if (r_cnt == LAST_CNT) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Start bit goes out on the grant edge; r_shift then holds the remaining 76 bits.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus_out <= 1'b0;
      r_shift <= '0;
      r_cnt   <= '0;
      r_ptr   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            bus_out <= w_frame[FRAME_W-1];
            r_shift <= {w_frame[FRAME_W-2:0], 1'b0};
            r_cnt   <= '0;
            r_ptr   <= w_win + 4'd1;
          end else begin
            bus_out <= 1'b0;
          end
        end
        SEND: begin
          if (r_cnt == LAST_CNT) begin
            bus_out <= 1'b0;
          end else begin
            bus_out <= r_shift[FRAME_W-1];
            r_shift <= {r_shift[FRAME_W-2:0], 1'b0};
            r_cnt   <= r_cnt + 7'd1;
          end
        end
        default: bus_out <= 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_fpga.sv
// Bench for fpga: directed scenarios plus random traffic, every bus bit
// compared against a queue-based frame model of the bus protocol.
module tb_fpga;
  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] mod;
  logic [63:0] data [16];
  logic [3:0]  crc  [16];
  logic [3:0]  ra   [16];
  logic        bus_out;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  bit q[$];
  int last_grant;

  always #5 clock = ~clock;

  fpga dut (
    .clock(clock), .reset(reset),
    .CRC1(crc[0]),   .CRC2(crc[1]),   .CRC3(crc[2]),   .CRC4(crc[3]),
    .CRC5(crc[4]),   .CRC6(crc[5]),   .CRC7(crc[6]),   .CRC8(crc[7]),
    .CRC9(crc[8]),   .CRC10(crc[9]),  .CRC11(crc[10]), .CRC12(crc[11]),
    .CRC13(crc[12]), .CRC14(crc[13]), .CRC15(crc[14]), .CRC16(crc[15]),
    .Data1(data[0]),   .Data2(data[1]),   .Data3(data[2]),   .Data4(data[3]),
    .Data5(data[4]),   .Data6(data[5]),   .Data7(data[6]),   .Data8(data[7]),
    .Data9(data[8]),   .Data10(data[9]),  .Data11(data[10]), .Data12(data[11]),
    .Data13(data[12]), .Data14(data[13]), .Data15(data[14]), .Data16(data[15]),
    .receiverAddr1(ra[0]),   .receiverAddr2(ra[1]),   .receiverAddr3(ra[2]),
    .receiverAddr4(ra[3]),   .receiverAddr5(ra[4]),   .receiverAddr6(ra[5]),
    .receiverAddr7(ra[6]),   .receiverAddr8(ra[7]),   .receiverAddr9(ra[8]),
    .receiverAddr10(ra[9]),  .receiverAddr11(ra[10]), .receiverAddr12(ra[11]),
    .receiverAddr13(ra[12]), .receiverAddr14(ra[13]), .receiverAddr15(ra[14]),
    .receiverAddr16(ra[15]),
    .mod(mod), .bus_out(bus_out)
  );

  function automatic void model_reset();
    q.delete();
    last_grant = 15;
  endfunction

  // When the line is free and someone requests, queue the winner's whole frame plus one gap bit.
  function automatic bit model_edge();
    int win;
    win = -1;
    if (q.size() == 0 && mod != 16'h0) begin
      for (int k = 1; k <= 16; k++) begin
        if (win < 0 && mod[(last_grant + k) % 16]) win = (last_grant + k) % 16;
      end
      last_grant = win;
      q.push_back(1'b1);
      for (int b = 3; b >= 0; b--)  q.push_back(win[b]);
      for (int b = 3; b >= 0; b--)  q.push_back(ra[win][b]);
      for (int b = 63; b >= 0; b--) q.push_back(data[win][b]);
      for (int b = 3; b >= 0; b--)  q.push_back(crc[win][b]);
      q.push_back(1'b0);
    end
    return (q.size() != 0) ? q.pop_front() : 1'b0;
  endfunction

  task automatic check(input string tag, input bit exp);
    checks++;
    assert (bus_out === exp)
      else begin
        failures++;
        $error("FAIL %s cyc=%0d bus_out=%0b expected=%0b", tag, cyc, bus_out, exp);
      end
  endtask

  task automatic step(input string tag);
    bit exp;
    @(posedge clock);
    cyc++;
    if (reset) begin
      model_reset();
      exp = 1'b0;
    end else begin
      exp = model_edge();
    end
    #1;
    check(tag, exp);
  endtask

  task automatic steps(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic async_reset(input string tag);
    reset = 1'b1;
    #1;
    model_reset();
    check(tag, 1'b0);
    step(tag);
    reset = 1'b0;
  endtask

  task automatic clear_inputs();
    mod = '0;
    for (int i = 0; i < 16; i++) begin
      data[i] = '0; crc[i] = '0; ra[i] = '0;
    end
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < 16; i++) begin
      data[i] = {$urandom, $urandom};
      crc[i]  = 4'($urandom);
      ra[i]   = 4'($urandom);
    end
  endtask

  initial begin
    clear_inputs();
    model_reset();
    reset = 1'b1;
    #1;
    check("reset_state", 1'b0);
    steps("in_reset", 2);
    reset = 1'b0;

    // Single sender, back-to-back frames
    data[0] = 64'd1; crc[0] = 4'd1; ra[0] = 4'd1; mod = 16'h0001;
    steps("single", 160);

    // No request
    async_reset("rst_norq");
    mod = '0;
    for (int i = 0; i < 200; i++) begin
      rand_inputs();
      step("no_req");
    end

    // Two senders alternate
    async_reset("rst_rr");
    clear_inputs();
    data[0] = '1; data[1] = '0; crc[0] = 4'hA; crc[1] = 4'h5; ra[0] = 4'h3; ra[1] = 4'hC;
    mod = 16'h0003;
    steps("rr_two", 320);

    // Wrap-around between senders 16 and 1
    async_reset("rst_wrap");
    rand_inputs();
    mod = 16'h8001;
    steps("wrap", 240);

    // Payload is latched at grant
    async_reset("rst_latch");
    clear_inputs();
    data[0] = 64'd1; crc[0] = 4'd1; ra[0] = 4'd1; mod = 16'h0001;
    steps("latch_a", 20);
    data[0] = 64'hA5A5_A5A5_A5A5_A5A5;
    steps("latch_b", 140);

    // Reset mid-frame, then fresh frame from sender 2
    async_reset("rst_mid0");
    mod = 16'h0001;
    steps("mid_frame", 30);
    mod = 16'h0002;
    data[1] = 64'h0123_4567_89AB_CDEF; crc[1] = 4'h9; ra[1] = 4'h6;
    async_reset("rst_mid");
    steps("after_rst", 90);

    // Random traffic with inputs changing underneath frames
    for (int i = 0; i < 1600; i++) begin
      if ($urandom_range(0, 15) == 0)
        mod = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom) & 16'($urandom);
      if ($urandom_range(0, 3) == 0) rand_inputs();
      if (i == 800) async_reset("rst_rand");
      step("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fpga.md
Name: fpga

Overview:
- Shared serial-bus transmitter for 16 sender ports.
- Each sender presents a 64-bit payload, a 4-bit CRC and a 4-bit receiver address, plus one request bit in `mod`.
- A round-robin arbiter grants one requesting sender at a time. The granted frame is latched and shifted out MSB-first on the single-bit `bus_out`.
- Sits at the top of the bus node; the CRC is supplied by each sender and is not computed here.

Parameters:
- None. All widths are fixed: 16 senders, 64-bit data, 4-bit CRC, 4-bit addresses.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- CRC1..CRC16  input  4 each  CRC field of sender n.
- Data1..Data16  input  64 each  payload of sender n.
- receiverAddr1..receiverAddr16  input  4 each  destination address of sender n.
- mod  input  16  request vector; bit n-1 = 1 means sender n wants the bus.
- bus_out  output  1  registered serial bus line.

Behaviour:
- Reset (asynchronous, active-high):
  - bus_out=0, state=IDLE, shift register cleared, bit counter=0.
  - Round-robin pointer set so sender 1 has highest priority.
- Frame format, 77 bits, transmitted MSB-first in this order:
  - start bit (1)
  - sender address (4 bits, value n-1 for sender n)
  - receiverAddr (4 bits)
  - Data (64 bits, bit 63 first)
  - CRC (4 bits, bit 3 first)
- Idle line level is 0.
- IDLE state:
  - bus_out=0.
  - On a rising edge with mod!=0: pick the winner, latch its full frame into a 77-bit shift register, drive bus_out<=1 (start bit) on that same edge, go to SEND.
- SEND state:
  - Each following edge shifts out the next frame bit; bits 2..77 appear on edges E1..E76 after the start edge E0.
- GAP:
  - At edge E77: bus_out<=0, return to IDLE.
  - Arbitration is not evaluated at E77, so at least one 0 gap bit separates frames.
  - Minimum frame period is 78 cycles.
- Arbitration (round robin):
  - Search starts at the sender after the last granted one, wrapping 16 -> 1. First sender with its mod bit set wins.
  - After reset the search starts at sender 1.
  - The pointer updates only at a grant.
- Input changes (Data/CRC/addr/mod) during SEND or GAP are ignored. The frame content is frozen at grant.
- `mod` is level-sensitive. A sender whose bit stays high is re-granted whenever it wins arbitration; with a single requester it transmits back-to-back with the 1-cycle gap.
- Reset asserted mid-frame: frame aborted immediately, bus_out=0, no resume after release.
- mod=0 forever: bus_out stays 0.
- No X propagation: bus_out is always a defined register value.

Test Plan:
- Single sender, back-to-back frames:
  - Stimulus: reset pulse, then mod=16'h0001, Data1=1, CRC1=1, receiverAddr1=1.
  - Response: first edge after reset release gives bus_out bits 1, 0000, 0001, 63 zeros, 1, 0001, then a single 0.
  - The identical frame repeats every 78 cycles.
- No request:
  - Stimulus: mod=0 with arbitrary Data/CRC/addr values for 200 cycles.
  - Response: bus_out remains 0 throughout.
- Round robin between two senders:
  - Stimulus: mod=16'h0003, Data1=64'hFFFF_FFFF_FFFF_FFFF, Data2=0.
  - Response: frames alternate sender address 0000, 0001, 0000, ..., each with its own payload.
- Wrap-around:
  - Stimulus: mod=16'h8001.
  - Response: sender 1 is granted first (address 0000), then sender 16 (address 1111), then sender 1 again.
- Latching:
  - Stimulus: change Data1 from 1 to 64'hA5A5_A5A5_A5A5_A5A5 at cycle 20 of a frame.
  - Response: the current frame still carries payload 1; the next frame carries A5A5...
- Reset mid-frame:
  - Stimulus: assert reset at cycle 30 of a frame.
  - Response: bus_out=0 immediately, asynchronously. After release with mod=16'h0002, a fresh full frame from sender 2 starts on the first edge.
